// File: rtl/tile_row_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_row_streamer_pkg
// Purpose  : Shared state encoding and default sizing for tile_row_streamer.
// Revision : 1.0 - initial release
// ============================================================================
package tile_row_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT_RD = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int TILE_ROWS  = 4;
    localparam int ROW_DATA_W = 64;

endpackage
`default_nettype wire

// File: rtl/tile_row_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : tile_row_streamer_if
// Purpose  : Request, scratchpad-read and row-stream signals of the streamer.
// Revision : 1.0 - initial release
// ============================================================================
interface tile_row_streamer_if
    import tile_row_streamer_pkg::*;
#(
    parameter int DATA_W = ROW_DATA_W,
    parameter int ADDR_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_base_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [7:0]        out_row_idx;
    logic              busy;
    logic              done;

    // The streamer is the responder; the control FSM / scratchpad / array side is master.
    modport slave (
        input  req_valid, req_base_addr, rd_data, out_ready,
        output req_ready, rd_en, rd_addr, out_valid, out_data, out_last,
               out_row_idx, busy, done
    );

    modport master (
        output req_valid, req_base_addr, rd_data, out_ready,
        input  req_ready, rd_en, rd_addr, out_valid, out_data, out_last,
               out_row_idx, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/tile_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tile_row_streamer
// Purpose  : Reads ROWS scratchpad rows per tile request and streams them out.
//            Optional stall counter: TILE_STREAM_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tile_row_streamer
    import tile_row_streamer_pkg::*;
#(
    parameter int DATA_W = ROW_DATA_W,
    parameter int ROWS   = TILE_ROWS,
    parameter int ADDR_W = 8
) (
    input  wire logic          CLK,
    input  wire logic          nRST,
`ifdef TILE_STREAM_STALL_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    tile_row_streamer_if.slave bus
);

    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        row_cnt_q, row_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [7:0]        out_idx_q, out_idx_d;
    logic              accept;
    logic              beat_fire;

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign beat_fire = (state_q == SEND) && bus.out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) state_d = FETCH;
            end
            FETCH: begin
                bus.rd_en   = 1'b1;
                // Natural ADDR_W truncation gives the modulo-2^ADDR_W wrap.
                bus.rd_addr = base_q + ADDR_W'(row_cnt_q);
                state_d     = WAIT_RD;
            end
            WAIT_RD: state_d = SEND;
            SEND: begin
                bus.out_valid = 1'b1;
                if (beat_fire) state_d = out_last_q ? DONE : FETCH;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d     = base_q;
        row_cnt_d  = row_cnt_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_idx_d  = out_idx_q;
        if (accept) begin
            base_d    = bus.req_base_addr;
            row_cnt_d = '0;
        end
        if (state_q == WAIT_RD) begin
            out_data_d = bus.rd_data;
            out_idx_d  = row_cnt_q;
            out_last_d = (row_cnt_q == LAST_ROW);
        end
        if (beat_fire && !out_last_q) row_cnt_d = row_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            base_q     <= '0;
            row_cnt_q  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_idx_q  <= '0;
        end else begin
            base_q     <= base_d;
            row_cnt_q  <= row_cnt_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_row_idx = out_idx_q;

`ifdef TILE_STREAM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept)
            stall_cnt_d = '0;
        else if ((state_q == SEND) && !bus.out_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_row_streamer
// Purpose  : Self-checking bench: random scratchpad contents and backpressure
//            against a row-list reference model. Honours TILE_STREAM_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_row_streamer;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 8;
    localparam int ROWS   = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    tile_row_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    tile_row_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

`ifdef TILE_STREAM_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt1;
`endif

    tile_row_streamer #(.DATA_W(DATA_W), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
`ifdef TILE_STREAM_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .bus      (bus)
    );

    tile_row_streamer #(.DATA_W(DATA_W), .ROWS(1), .ADDR_W(ADDR_W)) u_dut1 (
        .CLK      (CLK),
        .nRST     (nRST),
`ifdef TILE_STREAM_STALL_CNT_EN
        .stall_cnt(stall_cnt1),
`endif
        .bus      (bus1)
    );

    // Scratchpad model: one-cycle read latency, junk on the bus when not reading.
    logic [DATA_W-1:0] mem [256];
    always @(posedge CLK) begin
        if (bus.rd_en)  bus.rd_data  <= mem[bus.rd_addr];
        else            bus.rd_data  <= {$urandom, $urandom};
        if (bus1.rd_en) bus1.rd_data <= mem[bus1.rd_addr];
        else            bus1.rd_data <= {$urandom, $urandom};
    end

    int checks   = 0;
    int failures = 0;

    // Observations of one tile, filled by run_tile.
    logic [DATA_W-1:0] beat_data [$];
    logic [7:0]        beat_idx  [$];
    logic              beat_last [$];
    int                rd_q      [$];
    int first_rd_cyc, first_val_cyc, last_hs_cyc, done_cyc, done_cnt;
    int busy_err, rdy_err, stab_err, second_rd_cyc, stalled;
    logic [15:0] stall_at_done;

    task automatic run_tile(input logic [7:0] base, input bit rand_rdy,
                            input int stall_row, input int stall_len, input bit hold_req);
        int cyc, post, waited;
        bit prev_stall;
        logic [DATA_W-1:0] h_data;
        logic [7:0] h_idx;
        logic h_last;
        beat_data.delete(); beat_idx.delete(); beat_last.delete(); rd_q.delete();
        first_rd_cyc = -1; first_val_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        second_rd_cyc = -1; done_cnt = 0; busy_err = 0; rdy_err = 0; stab_err = 0;
        stalled = 0; stall_at_done = 16'hDEAD;
        @(negedge CLK);
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        bus.req_valid     = 1'b1;
        bus.req_base_addr = base;
        bus.out_ready     = 1'b0;
        cyc = 0; post = 0; prev_stall = 1'b0;
        h_data = '0; h_idx = '0; h_last = 1'b0;
        while (cyc < 400 && post < 3) begin
            @(negedge CLK);
            cyc++;
            if (!hold_req) bus.req_valid = 1'b0;
            if (prev_stall && (!bus.out_valid || bus.out_data !== h_data ||
                               bus.out_row_idx !== h_idx || bus.out_last !== h_last))
                stab_err++;
            if (bus.rd_en) begin
                if (done_cyc < 0) begin
                    rd_q.push_back(int'(bus.rd_addr));
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                end else if (second_rd_cyc < 0) second_rd_cyc = cyc;
            end
            if (done_cyc < 0) begin
                if (!bus.busy) busy_err++;
                if (bus.req_ready) rdy_err++;
            end
            if (bus.out_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (stall_row >= 0)
                bus.out_ready = !(bus.out_valid && int'(bus.out_row_idx) == stall_row && stalled < stall_len);
            else if (rand_rdy)
                bus.out_ready = 1'($urandom_range(0, 1));
            else
                bus.out_ready = 1'b1;
            if (bus.out_valid && !bus.out_ready && done_cyc < 0) stalled++;
            prev_stall = bus.out_valid && !bus.out_ready;
            h_data = bus.out_data; h_idx = bus.out_row_idx; h_last = bus.out_last;
            if (bus.out_valid && bus.out_ready && done_cyc < 0) begin
                beat_data.push_back(bus.out_data);
                beat_idx.push_back(bus.out_row_idx);
                beat_last.push_back(bus.out_last);
                if (bus.out_last) last_hs_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
`ifdef TILE_STREAM_STALL_CNT_EN
                    stall_at_done = stall_cnt;
`endif
                end
            end
            if (done_cyc >= 0) post++;
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.req_ready, bus.rd_en, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags: got rdy/rd/val/last/busy/done=%b want 100000",
                     {bus.req_ready, bus.rd_en, bus.out_valid, bus.out_last, bus.busy, bus.done});
        end
        checks++;
        if (bus.out_data !== '0 || bus.rd_addr !== '0 || bus.out_row_idx !== '0) begin
            failures++;
            $display("FAIL reset_data: got data=%h addr=%h idx=%h want all 0",
                     bus.out_data, bus.rd_addr, bus.out_row_idx);
        end
`ifdef TILE_STREAM_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_stall: got %0d want 0", stall_cnt);
        end
`endif
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_basic_tile();
        logic [7:0] base, ea;
        base = 8'h10;
        run_tile(base, 1'b0, -1, 0, 1'b0);
        checks++;
        if (rd_q.size() != ROWS) begin
            failures++;
            $display("FAIL basic_nreads: got %0d want %0d", rd_q.size(), ROWS);
        end
        for (int k = 0; k < rd_q.size() && k < ROWS; k++) begin
            ea = base + 8'(k);
            checks++;
            if (rd_q[k] != int'(ea)) begin
                failures++;
                $display("FAIL basic_rdaddr%0d: got %h want %h", k, rd_q[k], ea);
            end
        end
        checks++;
        if (beat_data.size() != ROWS) begin
            failures++;
            $display("FAIL basic_nbeats: got %0d want %0d", beat_data.size(), ROWS);
        end
        for (int k = 0; k < beat_data.size() && k < ROWS; k++) begin
            ea = base + 8'(k);
            checks++;
            if (beat_data[k] !== mem[ea] || beat_idx[k] !== 8'(k) || beat_last[k] !== (k == ROWS-1)) begin
                failures++;
                $display("FAIL basic_beat%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         k, beat_data[k], beat_idx[k], beat_last[k], mem[ea], k, (k == ROWS-1));
            end
        end
        checks++;
        if (first_rd_cyc != 1 || first_val_cyc != 3) begin
            failures++;
            $display("FAIL basic_latency: got rd_en@%0d valid@%0d want rd_en@1 valid@3", first_rd_cyc, first_val_cyc);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 3 * ROWS + 1) begin
            failures++;
            $display("FAIL basic_done: got count=%0d at %0d want count=1 at %0d", done_cnt, done_cyc, 3 * ROWS + 1);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL basic_busy: got %0d low-busy cycles want 0", busy_err);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] base, ea;
        base = 8'($urandom);
        run_tile(base, 1'b0, 1, 5, 1'b0);
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stab_err);
        end
        checks++;
        if (rd_q.size() != ROWS) begin
            failures++;
            $display("FAIL bp_nreads: got %0d want %0d", rd_q.size(), ROWS);
        end
        checks++;
        if (stalled != 5 || done_cyc != 3 * ROWS + 1 + 5 || done_cnt != 1) begin
            failures++;
            $display("FAIL bp_done: got stalls=%0d done@%0d count=%0d want stalls=5 done@%0d count=1",
                     stalled, done_cyc, done_cnt, 3 * ROWS + 6);
        end
        for (int k = 0; k < beat_data.size() && k < ROWS; k++) begin
            ea = base + 8'(k);
            checks++;
            if (beat_data[k] !== mem[ea] || beat_idx[k] !== 8'(k) || beat_last[k] !== (k == ROWS-1)) begin
                failures++;
                $display("FAIL bp_beat%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         k, beat_data[k], beat_idx[k], beat_last[k], mem[ea], k, (k == ROWS-1));
            end
        end
`ifdef TILE_STREAM_STALL_CNT_EN
        checks++;
        if (stall_at_done !== 16'd5) begin
            failures++;
            $display("FAIL bp_stall_cnt: got %0d want 5", stall_at_done);
        end
`endif
    endtask

    task automatic test_addr_wrap();
        int want [4];
        want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        run_tile(8'hFE, 1'b0, -1, 0, 1'b0);
        checks++;
        if (rd_q.size() != 4) begin
            failures++;
            $display("FAIL wrap_nreads: got %0d want 4", rd_q.size());
        end
        for (int k = 0; k < rd_q.size() && k < 4; k++) begin
            checks++;
            if (rd_q[k] != want[k] || beat_data.size() <= k || beat_data[k] !== mem[want[k]]) begin
                failures++;
                $display("FAIL wrap_row%0d: got addr=%h want addr=%h", k, rd_q[k], want[k]);
            end
        end
    endtask

    task automatic test_random_tiles();
        logic [7:0] base, ea;
        for (int t = 0; t < 4; t++) begin
            base = 8'($urandom);
            run_tile(base, 1'b1, -1, 0, 1'b0);
            checks++;
            if (beat_data.size() != ROWS || done_cnt != 1 || done_cyc != last_hs_cyc + 1 || stab_err != 0) begin
                failures++;
                $display("FAIL rand%0d_shape: got beats=%0d done=%0d@%0d lasths@%0d unstable=%0d want %0d beats, 1 done after last hs",
                         t, beat_data.size(), done_cnt, done_cyc, last_hs_cyc, stab_err, ROWS);
            end
            for (int k = 0; k < beat_data.size() && k < ROWS; k++) begin
                ea = base + 8'(k);
                checks++;
                if (beat_data[k] !== mem[ea] || beat_idx[k] !== 8'(k) || beat_last[k] !== (k == ROWS-1)) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                             t, k, beat_data[k], beat_idx[k], beat_last[k], mem[ea], k, (k == ROWS-1));
                end
            end
`ifdef TILE_STREAM_STALL_CNT_EN
            checks++;
            if (stall_at_done !== 16'(stalled)) begin
                failures++;
                $display("FAIL rand%0d_stall_cnt: got %0d want %0d", t, stall_at_done, stalled);
            end
`endif
        end
    endtask

    task automatic test_req_while_busy();
        int w;
        run_tile(8'h40, 1'b0, -1, 0, 1'b1);
        checks++;
        if (rdy_err != 0 || rd_q.size() != ROWS) begin
            failures++;
            $display("FAIL busy_req_ready: got %0d ready cycles, %0d reads want 0 ready, %0d reads", rdy_err, rd_q.size(), ROWS);
        end
        checks++;
        if (done_cyc < 0 || second_rd_cyc != done_cyc + 2) begin
            failures++;
            $display("FAIL busy_restart: got second rd_en@%0d want %0d", second_rd_cyc, done_cyc + 2);
        end
        bus.out_ready = 1'b1;
        w = 0;
        while (!bus.done && w < 60) begin
            @(negedge CLK);
            w++;
        end
        checks++;
        if (!bus.done) begin
            failures++;
            $display("FAIL busy_second_done: got no done within 60 cycles want done");
        end
        @(negedge CLK);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_tile();
        logic [7:0] base;
        bit hit;
        int seen;
        base = 8'($urandom);
        @(negedge CLK);
        bus.req_valid = 1'b1; bus.req_base_addr = base; bus.out_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge CLK);
            bus.req_valid = 1'b0;
            if (bus.out_valid && bus.out_row_idx == 8'd2) begin
                hit = 1'b1;
                bus.out_ready = 1'b0;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_mid_reach: got no row-2 beat want row-2 beat");
        end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rd_en, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 6'b100000 ||
            bus.out_data !== '0 || bus.out_row_idx !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got flags=%b data=%h idx=%h want flags=100000 data=0 idx=0",
                     {bus.req_ready, bus.rd_en, bus.out_valid, bus.out_last, bus.busy, bus.done},
                     bus.out_data, bus.out_row_idx);
        end
        @(negedge CLK);
        nRST = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge CLK);
            if (bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: got %0d done/busy cycles want 0", seen);
        end
        base = 8'($urandom);
        run_tile(base, 1'b0, -1, 0, 1'b0);
        checks++;
        if (beat_data.size() != ROWS || beat_idx[0] !== 8'd0 || beat_data[0] !== mem[base] || done_cnt != 1) begin
            failures++;
            $display("FAIL rst_mid_restart: got beats=%0d first idx=%0d data=%h done=%0d want %0d beats idx=0 data=%h done=1",
                     beat_data.size(), beat_idx[0], beat_data[0], done_cnt, ROWS, mem[base]);
        end
    endtask

    task automatic test_rows1();
        logic [7:0] base, idx;
        logic [DATA_W-1:0] d;
        logic l;
        int nbeat, hs, dc;
        base = 8'($urandom);
        @(negedge CLK);
        bus1.req_valid = 1'b1; bus1.req_base_addr = base; bus1.out_ready = 1'b1;
        nbeat = 0; hs = -1; dc = -1; d = '0; l = 1'b0; idx = 8'hFF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            bus1.req_valid = 1'b0;
            if (bus1.out_valid && bus1.out_ready) begin
                nbeat++; hs = c; d = bus1.out_data; l = bus1.out_last; idx = bus1.out_row_idx;
            end
            if (bus1.done && dc < 0) dc = c;
        end
        checks++;
        if (nbeat != 1 || l !== 1'b1 || idx !== 8'd0 || d !== mem[base]) begin
            failures++;
            $display("FAIL rows1_beat: got beats=%0d last=%b idx=%0d data=%h want 1 beat last=1 idx=0 data=%h",
                     nbeat, l, idx, d, mem[base]);
        end
        checks++;
        if (hs != 3 || dc != 4) begin
            failures++;
            $display("FAIL rows1_timing: got hs@%0d done@%0d want hs@3 done@4", hs, dc);
        end
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        bus.req_valid  = 1'b0; bus.req_base_addr  = '0; bus.out_ready  = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_base_addr = '0; bus1.out_ready = 1'b0;
        test_reset();
        test_basic_tile();
        test_backpressure();
        test_addr_wrap();
        test_random_tiles();
        test_req_while_busy();
        test_reset_mid_tile();
        test_rows1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
